// File: rtl/cnn_layer_sequencer.sv
// Phase sequencer: launches the L0 conv engine, then runs 2x2 max-pool (L1) and flatten (L2).
// Flatten phase is built only when CNN_SEQ_FLATTEN_EN is defined; IMG_W must be a power of two.
module cnn_layer_sequencer #(
  parameter int IMG_W = 64,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          conv_start,
  input  logic          conv_done,
  input  logic [2:0]    conv_csel,
  input  logic          conv_crd,
  input  logic          conv_cwr,
  input  logic [AW-1:0] conv_caddr_rd,
  input  logic [AW-1:0] conv_caddr_wr,
  input  logic [DW-1:0] conv_cdata_wr,
  output logic [2:0]    csel,
  output logic          crd,
  output logic          cwr,
  output logic [AW-1:0] caddr_rd,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd
);

  localparam int HW = IMG_W / 2;
  localparam int CW = $clog2(HW);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
`ifdef CNN_SEQ_FLATTEN_EN
  localparam logic [2:0] SEL_L2   = 3'b101;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV    = 3'd1,
    POOL_RD = 3'd2,
    POOL_WR = 3'd3,
`ifdef CNN_SEQ_FLATTEN_EN
    FLAT_RD = 3'd4,
    FLAT_WR = 3'd5,
`endif
    DONE    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            conv_start_q, conv_start_d;
  logic            busy_q, busy_d;
  logic            k_q, k_d;
  logic [CW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic [1:0]      j_q, j_d;
  logic [DW-1:0]   max_q, max_d;

  logic            last_c_s;
  logic            last_r_s;
  logic [DW-1:0]   pool_max_s;

  assign last_c_s   = (c_q == CW'(HW - 1));
  assign last_r_s   = (r_q == CW'(HW - 1));
  assign pool_max_s = (cdata_rd > max_q) ? cdata_rd : max_q;

  assign busy       = busy_q;
  assign conv_start = conv_start_q;

  // State, index counters and running max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      k_q          <= 1'b0;
      r_q          <= '0;
      c_q          <= '0;
      j_q          <= 2'd0;
      max_q        <= '0;
    end else begin
      state_q      <= state_d;
      conv_start_q <= conv_start_d;
      busy_q       <= busy_d;
      k_q          <= k_d;
      r_q          <= r_d;
      c_q          <= c_d;
      j_q          <= j_d;
      max_q        <= max_d;
    end
  end

  // Next-state, counter advance and running-max update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    j_d     = j_q;
    max_d   = max_q;
    case (state_q)
      IDLE: begin
        if (ready) state_d = CONV;
        else       state_d = IDLE;
      end
      CONV: begin
        if (conv_done) begin
          state_d = POOL_RD;
          k_d     = 1'b0;
          r_d     = '0;
          c_d     = '0;
          j_d     = 2'd0;
        end else begin
          state_d = CONV;
        end
      end
      POOL_RD: begin
        j_d = j_q + 2'd1;
        // Datum 0 arrives while j=1 is being issued; it seeds the max.
        if (j_q == 2'd1)      max_d = cdata_rd;
        else if (j_q != 2'd0) max_d = pool_max_s;
        else                  max_d = max_q;
        if (j_q == 2'd3) state_d = POOL_WR;
        else             state_d = POOL_RD;
      end
      POOL_WR: begin
        state_d = POOL_RD;
        j_d     = 2'd0;
        if (last_c_s) begin
          c_d = '0;
          if (last_r_s) begin
            r_d = '0;
            if (k_q) begin
              k_d = 1'b0;
`ifdef CNN_SEQ_FLATTEN_EN
              state_d = FLAT_RD;
`else
              state_d = DONE;
`endif
            end else begin
              k_d = 1'b1;
            end
          end else begin
            r_d = r_q + CW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
`ifdef CNN_SEQ_FLATTEN_EN
      FLAT_RD: begin
        state_d = FLAT_WR;
      end
      FLAT_WR: begin
        state_d = FLAT_RD;
        if (!k_q) begin
          k_d = 1'b1;
        end else begin
          k_d = 1'b0;
          if (last_c_s && last_r_s) begin
            state_d = DONE;
            r_d     = '0;
            c_d     = '0;
          end else if (last_c_s) begin
            c_d = '0;
            r_d = r_q + CW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    conv_start_d = (state_q == IDLE) && ready;
    busy_d       = (state_d != IDLE) && (state_d != DONE);
  end

  // Memory port: conv pass-through in CONV, sequencer traffic otherwise.
  always_comb begin
    csel     = SEL_NONE;
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    case (state_q)
      CONV: begin
        csel     = conv_csel;
        crd      = conv_crd;
        cwr      = conv_cwr;
        caddr_rd = conv_caddr_rd;
        caddr_wr = conv_caddr_wr;
        cdata_wr = conv_cdata_wr;
      end
      POOL_RD: begin
        crd      = 1'b1;
        csel     = k_q ? SEL_L0K1 : SEL_L0K0;
        // {r, j[1], c, j[0]} = (2r + j[1]) * IMG_W + 2c + j[0]
        caddr_rd = AW'({r_q, j_q[1], c_q, j_q[0]});
      end
      POOL_WR: begin
        cwr      = 1'b1;
        csel     = k_q ? SEL_L1K1 : SEL_L1K0;
        caddr_wr = AW'({r_q, c_q});
        cdata_wr = pool_max_s;
      end
`ifdef CNN_SEQ_FLATTEN_EN
      FLAT_RD: begin
        crd      = 1'b1;
        csel     = k_q ? SEL_L1K1 : SEL_L1K0;
        caddr_rd = AW'({r_q, c_q});
      end
      FLAT_WR: begin
        cwr      = 1'b1;
        csel     = SEL_L2;
        caddr_wr = AW'({r_q, c_q, k_q});
        cdata_wr = cdata_rd;
      end
`endif
      default: begin
        csel = SEL_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: memory model, conv stub and write scoreboard.
module tb_cnn_layer_sequencer;

  localparam int DW = 20;
  localparam int AW = 12;
`ifdef CNN_SEQ_FLATTEN_EN
  localparam int LAT  = 14337;
  localparam bit FLAT = 1'b1;
`else
  localparam int LAT  = 10241;
  localparam bit FLAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          busy;
  logic          conv_start;
  logic          conv_done;
  logic [2:0]    conv_csel;
  logic          conv_crd;
  logic          conv_cwr;
  logic [AW-1:0] conv_caddr_rd;
  logic [AW-1:0] conv_caddr_wr;
  logic [DW-1:0] conv_cdata_wr;
  logic [2:0]    csel;
  logic          crd;
  logic          cwr;
  logic [AW-1:0] caddr_rd;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [DW-1:0] cdata_rd;

  cnn_layer_sequencer #(.IMG_W(64), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .conv_start(conv_start),
    .conv_done(conv_done), .conv_csel(conv_csel), .conv_crd(conv_crd), .conv_cwr(conv_cwr),
    .conv_caddr_rd(conv_caddr_rd), .conv_caddr_wr(conv_caddr_wr), .conv_cdata_wr(conv_cdata_wr),
    .csel(csel), .crd(crd), .cwr(cwr), .caddr_rd(caddr_rd), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  typedef logic [3+AW+DW-1:0] wr_t;
  wr_t           exp_q[$];
  logic [DW-1:0] mem [0:7][0:4095];
  int            tests, fails;
  int            cyc;
  bit            in_conv;
  int            starts;
  int            done_cyc, fall_cyc, first_wr_cyc;
  bit            busy_prev;
  logic          fill_req, pl_en;
  logic [2:0]    pl_sel;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Result memories: one-cycle read latency, random data when not read.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int s = 1; s < 6; s++)
        for (int a = 0; a < 4096; a++) mem[s][a] <= DW'($urandom);
    end else if (pl_en) begin
      mem[pl_sel][pl_addr] <= pl_data;
    end else if (cwr && csel != 3'd0) begin
      mem[csel][caddr_wr] <= cdata_wr;
    end
    if (crd) cdata_rd <= mem[csel][caddr_rd];
    else     cdata_rd <= DW'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (reset && !in_conv) begin
      check("drive_rule", 64'(crd & cwr), 64'd0);
`ifndef CNN_SEQ_FLATTEN_EN
      check("no_l2_select", 64'(csel === 3'b101), 64'd0);
`endif
      if (cwr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("write", 64'({csel, caddr_wr, cdata_wr}), 64'(e));
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
      end
    end
    if (in_conv && conv_start) starts++;
    if (busy_prev && !busy && fall_cyc < 0) fall_cyc = cyc;
    busy_prev = busy;
  endtask

  task automatic poke(input logic [2:0] s, input int a, input logic [DW-1:0] d);
    pl_sel = s; pl_addr = AW'(a); pl_data = d; pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic fill();
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_start"}, 64'(conv_start), 64'd0);
    check({tag, "_port"}, 64'({csel, crd, cwr, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
  endtask

  task automatic build_expected();
    logic [DW-1:0] l1 [0:1][0:1023];
    logic [DW-1:0] m, d;
    exp_q.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) begin
          m = mem[1+k][(2*r)*64 + 2*c];
          for (int j = 1; j < 4; j++) begin
            d = mem[1+k][(2*r + j/2)*64 + 2*c + j%2];
            if (d > m) m = d;
          end
          l1[k][r*32+c] = m;
          exp_q.push_back({3'(3+k), AW'(r*32+c), m});
        end
    if (FLAT)
      for (int i = 0; i < 1024; i++)
        for (int k = 0; k < 2; k++) exp_q.push_back({3'd5, AW'(2*i+k), l1[k][i]});
  endtask

  task automatic launch_and_finish_conv();
    starts  = 0;
    in_conv = 1'b1;
    ready   = 1'b1;
    tick();
    check("launch_start", 64'(conv_start), 64'd1);
    check("launch_busy", 64'(busy), 64'd1);
    check("pass_wr", 64'({csel, cwr, caddr_wr, cdata_wr}), 64'({3'b001, 1'b1, 12'h123, 20'h0ABCD}));
    check("pass_rd", 64'({crd, caddr_rd}), 64'({1'b1, 12'h456}));
    ready = 1'b0;
    repeat (19) tick();
    check("start_pulses", 64'(starts), 64'd1);
    build_expected();
    done_cyc     = cyc;
    fall_cyc     = -1;
    first_wr_cyc = -1;
    conv_done    = 1'b1;
    @(posedge clk);
    #1;
    conv_done = 1'b0;
    in_conv   = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 20000) begin
      tick();
      n++;
    end
    check("busy_fall_latency", 64'(fall_cyc - done_cyc), 64'(LAT));
    check("first_pool_write", 64'(first_wr_cyc - done_cyc), 64'd5);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    tick();
    check_zero("idle_after_done");
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ready = 1'b0; conv_done = 1'b0;
    fill_req = 1'b0; pl_en = 1'b0; pl_sel = 3'd0; pl_addr = '0; pl_data = '0;
    conv_csel = 3'b001; conv_crd = 1'b1; conv_cwr = 1'b1;
    conv_caddr_rd = 12'h456; conv_caddr_wr = 12'h123; conv_cdata_wr = 20'h0ABCD;
    in_conv = 1'b0; busy_prev = 1'b0;
    repeat (3) tick();
    check_zero("in_reset");
    reset = 1'b1;
    tick();
    check_zero("idle");

    // Run A: pooling values, stray conv_done/ready during POOL.
    fill();
    poke(3'd1, 0, 20'd5);        poke(3'd1, 1, 20'd9);
    poke(3'd1, 64, 20'd3);       poke(3'd1, 65, 20'd7);
    poke(3'd2, 4030, 20'h80000); poke(3'd2, 4031, 20'h80000);
    poke(3'd2, 4094, 20'd1);     poke(3'd2, 4095, 20'd2);
    launch_and_finish_conv();
    repeat (50) tick();
    conv_done = 1'b1; ready = 1'b1;
    tick();
    conv_done = 1'b0; ready = 1'b0;
    wait_done();
    check("l1k0_0", 64'(mem[3][0]), 64'd9);
    check("l1k1_1023_tie", 64'(mem[4][1023]), 64'h80000);

    // Run B: reset in the middle of POOL.
    launch_and_finish_conv();
    repeat (37) tick();
    reset = 1'b0;
    #1;
    check_zero("reset_mid_pool");
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_zero("idle_after_reset");

    // Run C: fresh full run with flatten values.
    fill();
    poke(3'd1, 0, 20'd3);        poke(3'd1, 1, 20'h0000A);
    poke(3'd1, 64, 20'd2);       poke(3'd1, 65, 20'd1);
    poke(3'd2, 0, 20'h0000B);    poke(3'd2, 1, 20'd4);
    poke(3'd2, 64, 20'd0);       poke(3'd2, 65, 20'h0000B);
    poke(3'd2, 4030, 20'hFFFFF); poke(3'd2, 4031, 20'd0);
    poke(3'd2, 4094, 20'd5);     poke(3'd2, 4095, 20'd7);
    launch_and_finish_conv();
    wait_done();
    check("l1k0_0_c", 64'(mem[3][0]), 64'h0000A);
    check("l1k1_0_c", 64'(mem[4][0]), 64'h0000B);
    check("l1k1_1023_c", 64'(mem[4][1023]), 64'hFFFFF);
`ifdef CNN_SEQ_FLATTEN_EN
    check("l2_0", 64'(mem[5][0]), 64'h0000A);
    check("l2_1", 64'(mem[5][1]), 64'h0000B);
    check("l2_2047", 64'(mem[5][2047]), 64'hFFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Top-level phase sequencer for the convolutional image computation flow, sitting between the testbench handshake (`ready`/`busy`) and the shared result-memory port (`csel`/`crd`/`cwr`). It launches the Layer-0 convolution engine and passes its memory traffic through while the engine runs. After the engine finishes, it takes the port back and performs the Layer-1 2×2 max-pooling and the Layer-2 flatten. It owns the only path to the result memories, so exactly one agent drives `csel` at any time.

## Interface
- `IMG_W`, 64, Layer-0 image width/height in pixels.
- `DW`, 20, result data width.
- `AW`, 12, result memory address width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ready`  in  1  image ready; level, sampled only in IDLE.
- `busy`  out  1  high from launch until the final write completes.
- `conv_start`  out  1  one-cycle launch pulse to the conv engine.
- `conv_done`  in  1  one-cycle pulse from the conv engine after its last L0 write.
- `conv_csel`  in  3  conv engine's memory select.
- `conv_crd`, `conv_cwr`  in  1  conv engine's read and write enables.
- `conv_caddr_rd`, `conv_caddr_wr`  in  AW  conv engine's read and write addresses.
- `conv_cdata_wr`  in  DW  conv engine's write data.
- `csel`  out  3  memory select: 000 none, 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1, 101 L2.
- `crd`, `cwr`  out  1  read and write enables.
- `caddr_rd`, `caddr_wr`  out  AW  read and write addresses.
- `cdata_wr`  out  DW  write data.
- `cdata_rd`  in  DW  read data; valid in the cycle after `crd` is sampled high.

## Operation
- **States:** IDLE, CONV, POOL_RD, POOL_WR, FLAT_RD, FLAT_WR, DONE.
- **IDLE:**
  - All memory outputs are 0; `busy`=0.
  - If `ready`=1, the next state is CONV.
- **CONV:**
  - `busy`=1.
  - `conv_start`=1 in the first CONV cycle only.
  - All `c*` outputs are combinational pass-throughs of the `conv_*` inputs.
  - `conv_done`=1 moves the state to POOL_RD with kernel k=0, row r=0, column c=0.
- **POOL:**
  - For k∈{0,1}, r∈0..31, c∈0..31: read L0Kk at addresses (2r)·64+2c, +1, +64, +65, in that order. Issue reads on sub-index j=0..3 in POOL_RD, one per cycle.
  - The running max is loaded from the first datum and updated by unsigned compare. On ties, the value is unchanged.
  - In POOL_WR: `cwr`=1, `csel`=L1Kk, `caddr_wr`=r·32+c, `cdata_wr`=max(running max, 4th datum).
  - Index order: c increments fastest, then r, then k.
  - After the write for k=1, r=31, c=31, go to FLAT_RD (or DONE; see Configuration).
- **FLAT:**
  - For i∈0..1023, k∈{0,1} (k fastest):
    - FLAT_RD: read L1Kk[i].
    - FLAT_WR: write L2[2i+k] with that datum.
  - After L2[2047] is written, go to DONE.
- **DONE:**
  - `busy`=0 and all outputs 0.
  - The next state is IDLE.
  - A new run starts when `ready` is 1 in IDLE.
- **Ignored inputs:**
  - `conv_done` is ignored outside CONV.
  - `conv_*` inputs are ignored outside CONV.
  - `ready` is ignored outside IDLE.
- **Drive rule:** `crd` and `cwr` are never both 1 outside CONV.
- **Reset:**
  - All outputs go to 0 immediately; state returns to IDLE; counters clear.
  - This applies in any state, including mid-phase. There is no resume.

## Timing
- Launch: `ready` sampled 1 at edge t; CONV state, `busy`=1 and `conv_start`=1 are visible after edge t; `conv_start` drops after edge t+1.
- POOL: 5 cycles per output (4 reads, 1 write). Datum j arrives in the cycle after read j is issued; the 4th datum is consumed combinationally in POOL_WR. Total 2048×5 = 10240 cycles.
- FLAT: 2 cycles per output; total 4096 cycles.
- From `conv_done` sampled high to `busy` low:
  - with flatten: 10240 + 4096 + 1 cycles;
  - without flatten: 10240 + 1 cycles.
- Address counters never wrap mid-phase. All phase transitions happen on the terminal-count write cycle.

## Configuration
- `CNN_SEQ_FLATTEN_EN`:
  - **Defined:** the FLAT phase runs as described.
  - **Undefined:** FLAT_RD and FLAT_WR are not built; POOL's last write goes directly to DONE, and `csel`=101 never appears.

## Test plan
- **Reset:** hold `reset`=0 at random mid-run points → all outputs 0 within the same cycle; `busy`=0; state IDLE.
- **Launch and pass-through:** `ready`=1; conv stub drives `conv_cwr`=1, `conv_csel`=001, `conv_caddr_wr`=0x123, `conv_cdata_wr`=0x0ABCD, then pulses `conv_done` after 20 cycles.
  - Expect: exactly one `conv_start` pulse, 1 cycle after `ready` is sampled.
  - Expect: outputs mirror the stub values combinationally.
- **Pool:** preload L0K0[0]=5, [1]=9, [64]=3, [65]=7 and L0K1[4030]=0x80000, [4031]=0x80000, [4094]=1, [4095]=2.
  - Expect: L1K0[0]=9, written 5 cycles after POOL entry.
  - Expect: L1K1[1023]=0x80000 (tie held).
- **Flatten:** L1K0[0]=0x0000A, L1K1[0]=0x0000B, L1K1[1023]=0xFFFFF.
  - Expect: L2[0]=0x0000A, L2[1]=0x0000B, L2[2047]=0xFFFFF.
  - Expect: `busy` falls 14337 cycles after `conv_done`.
- **Reset mid-POOL and relaunch:** assert reset during POOL, release, raise `ready` → a complete fresh run from CONV; `conv_done` pulses during POOL are ignored.
- **Macro undefined:** `busy` falls 10241 cycles after `conv_done`; `csel` never equals 101.
